// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code-set-2 key decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_REL   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam int unsigned KEY_TOGGLE  = 10;
    localparam int unsigned KEY_PRESSED = 9;
    localparam int unsigned KEY_EXT     = 8;

    // Keyboard controller responses that never represent a key event.
    function automatic logic is_response(input logic [7:0] code);
        case (code)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one PS/2 line,
// with a registered falling-edge flag on the filtered level.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic filtered,
    output logic fall_edge
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '1;
            run_cnt   <= '0;
            filtered  <= 1'b1;
            fall_edge <= 1'b0;
        end else begin
            sync      <= {sync[0], line_in};
            fall_edge <= 1'b0;
            if (sync[1] != filtered) begin
                if (run_cnt == CW'(FILTER_LEN - 1)) begin
                    filtered  <= sync[1];
                    fall_edge <= filtered;
                    run_cnt   <= '0;
                end else begin
                    run_cnt <= run_cnt + 1'b1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver folding E0/F0/E1 prefixes into an 11-bit toggle-flagged
// key event word.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        frame_error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic            clk_filt;
    logic            clk_fall;
    logic            dat;
    ps2_state_t      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            parity_bit;
    logic            ext;
    logic            rel;
    logic [2:0]      pause_cnt;
    logic [TW-1:0]   tcount;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_clk_in),
        .filtered  (clk_filt),
        .fall_edge (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk       (clk),
        .reset     (reset),
        .line_in   (ps2_dat_in),
        .filtered  (dat),
        .fall_edge ()
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            parity_bit  <= 1'b0;
            ext         <= 1'b0;
            rel         <= 1'b0;
            pause_cnt   <= '0;
            tcount      <= '0;
            ps2_key     <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (clk_fall && !dat) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (clk_fall) begin
                        shreg   <= {dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    if (clk_fall) begin
                        parity_bit <= dat;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (clk_fall) begin
                        state <= IDLE;
                        if (!dat || !(^{shreg, parity_bit})) begin
                            frame_error <= 1'b1;
                            ext         <= 1'b0;
                            rel         <= 1'b0;
                        end else if (pause_cnt != '0) begin
                            pause_cnt <= pause_cnt - 1'b1;
                        end else if (shreg == PS2_PAUSE) begin
                            pause_cnt <= 3'd7;
                        end else if (shreg == PS2_EXT) begin
                            ext <= 1'b1;
                        end else if (shreg == PS2_REL) begin
                            rel <= 1'b1;
                        end else if (!(is_response(shreg) && !ext && !rel)) begin
                            ps2_key[KEY_TOGGLE]  <= ~ps2_key[KEY_TOGGLE];
                            ps2_key[KEY_PRESSED] <= ~rel;
                            ps2_key[KEY_EXT]     <= ext;
                            ps2_key[7:0]         <= shreg;
                            ext                  <= 1'b0;
                            rel                  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Timeout handling overrides the state update made above.
            if (state == IDLE || clk_fall) begin
                tcount <= '0;
            end else if (tcount >= TW'(TIMEOUT_CYCLES)) begin
                state       <= IDLE;
                frame_error <= 1'b1;
                ext         <= 1'b0;
                rel         <= 1'b0;
                tcount      <= '0;
            end else begin
                tcount <= tcount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder with a key-event scoreboard.
module tb_ps2_key_decoder;

    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 2000;
    localparam int unsigned HALF_BIT       = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_dat_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_error;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned err_count = 0;
    int unsigned exp_err = 0;
    logic [10:0] exp_q[$];
    logic [10:0] last_exp = 11'h000;
    logic [10:0] prev_key;

    ps2_key_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_dat_in  (ps2_dat_in),
        .ps2_key     (ps2_key),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            prev_key = ps2_key;
        end else begin
            if (frame_error === 1'b1)
                err_count++;
            if (ps2_key !== prev_key) begin
                checks++;
                assert (exp_q.size() > 0) begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    assert (ps2_key === e) passed++;
                    else $error("FAIL key_event observed=%h expected=%h", ps2_key, e);
                    passed++;
                end else $error("FAIL unexpected_event observed=%h expected=none", ps2_key);
                prev_key = ps2_key;
            end
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_dat_in = b;
        repeat (HALF_BIT / 2) @(posedge clk);
        ps2_clk_in = 1'b0;
        repeat (HALF_BIT) @(posedge clk);
        ps2_clk_in = 1'b1;
        repeat (HALF_BIT / 2) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_parity);
        logic p;
        p = ~(^b) ^ bad_parity;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        ps2_dat_in = 1'b1;
        repeat (100) @(posedge clk);
    endtask

    task automatic expect_key(input logic [10:0] k);
        exp_q.push_back(k);
        last_exp = k;
    endtask

    // Bounded wait for the scoreboard to empty, then check key and error count.
    task automatic settle(input string tag);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        assert (exp_q.size() == 0) passed++;
        else $error("FAIL %s_drain observed=%0d expected=0 pending", tag, exp_q.size());
        checks++;
        assert (ps2_key === last_exp) passed++;
        else $error("FAIL %s_key observed=%h expected=%h", tag, ps2_key, last_exp);
        checks++;
        assert (err_count === exp_err) passed++;
        else $error("FAIL %s_errors observed=%0d expected=%0d", tag, err_count, exp_err);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        assert (ps2_key === 11'h000) passed++;
        else $error("FAIL reset_key observed=%h expected=%h", ps2_key, 11'h000);
        checks++;
        assert (frame_error === 1'b0) passed++;
        else $error("FAIL reset_err observed=%b expected=0", frame_error);
        reset = 1'b0;
        repeat (20) @(posedge clk);

        expect_key(11'h61C);
        send_byte(8'h1C, 1'b0);
        settle("make_1c");

        send_byte(8'hF0, 1'b0);
        settle("f0_only");
        expect_key(11'h01C);
        send_byte(8'h1C, 1'b0);
        settle("break_1c");

        send_byte(8'hE0, 1'b0);
        expect_key(11'h774);
        send_byte(8'h74, 1'b0);
        settle("ext_make");
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        expect_key(11'h174);
        send_byte(8'h74, 1'b0);
        settle("ext_break");

        exp_err++;
        send_byte(8'h1C, 1'b1);
        settle("parity_err");
        expect_key(11'h615);
        send_byte(8'h15, 1'b0);
        settle("after_parity");

        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_dat_in = 1'b1;
        exp_err++;
        repeat (TIMEOUT_CYCLES + 200) @(posedge clk);
        settle("timeout");
        expect_key(11'h21C);
        send_byte(8'h1C, 1'b0);
        settle("after_timeout");

        ps2_dat_in = 1'b0;
        repeat (20) @(posedge clk);
        ps2_clk_in = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk_in = 1'b1;
        repeat (20) @(posedge clk);
        ps2_dat_in = 1'b1;
        repeat (50) @(posedge clk);
        send_byte(8'hAA, 1'b0);
        settle("glitch_aa");

        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        settle("pause_seq");
        expect_key(11'h61C);
        send_byte(8'h1C, 1'b0);
        settle("after_pause");

        send_byte(8'hE0, 1'b0);
        exp_err++;
        send_byte(8'h74, 1'b1);
        expect_key(11'h21C);
        send_byte(8'h1C, 1'b0);
        settle("prefix_drop");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
